// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes, coin values, cents width and
// the coin acceptor's FSM state type.
package vend_pkg;

    localparam int CENTS_W = 9;

    localparam int NICKEL_CENTS  = 5;
    localparam int DIME_CENTS    = 10;
    localparam int QUARTER_CENTS = 25;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COLLECT  = 2'b01,
        ST_DISPENSE = 2'b10
    } state_t;

endpackage

// File: rtl/coin_value_decode.sv
// Combinational map from a coin code to its value in cents plus a valid flag.
module coin_value_decode
    import vend_pkg::*;
#(
    parameter int NICKEL_C  = NICKEL_CENTS,
    parameter int DIME_C    = DIME_CENTS,
    parameter int QUARTER_C = QUARTER_CENTS
) (
    input  logic [1:0]         coin_type,
    output logic [CENTS_W-1:0] cents,
    output logic               valid
);

    always_comb begin
        cents = '0;
        valid = 1'b0;
        case (coin_type)
            COIN_NICKEL: begin
                cents = CENTS_W'(NICKEL_C);
                valid = 1'b1;
            end
            COIN_DIME: begin
                cents = CENTS_W'(DIME_C);
                valid = 1'b1;
            end
            COIN_QUARTER: begin
                cents = CENTS_W'(QUARTER_C);
                valid = 1'b1;
            end
            default: begin
                cents = '0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/coin_acceptor.sv
// Vending-machine front end: accumulates coin credit and resolves vend/cancel
// requests into a change amount for the change dispenser.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 500,
    parameter int NICKEL_C   = 5,
    parameter int DIME_C     = 10,
    parameter int QUARTER_C  = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       select_valid,
    input  logic [8:0] price,
    input  logic       cancel,
    output logic [8:0] credit,
    output logic       coin_reject,
    output logic       vend,
    output logic       sel_err,
    output logic [8:0] change,
    output logic       change_valid,
    output logic       busy
);

    state_t             state;
    logic [CENTS_W-1:0] coin_cents;
    logic               coin_ok;

    coin_value_decode #(
        .NICKEL_C  (NICKEL_C),
        .DIME_C    (DIME_C),
        .QUARTER_C (QUARTER_C)
    ) u_decode (
        .coin_type (coin_type),
        .cents     (coin_cents),
        .valid     (coin_ok)
    );

    // Widened by one bit so a full credit plus a quarter cannot wrap past the limit.
    function automatic logic coin_fits(input logic [CENTS_W-1:0] cur,
                                       input logic [CENTS_W-1:0] add);
        logic [CENTS_W:0] sum;
        sum = {1'b0, cur} + {1'b0, add};
        return sum <= (CENTS_W + 1)'(MAX_CREDIT);
    endfunction

    function automatic logic price_ok(input logic [CENTS_W-1:0] p,
                                      input logic [CENTS_W-1:0] cur);
        return (p != '0) && ((p % CENTS_W'(5)) == '0) && (p <= cur);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            credit       <= '0;
            change       <= '0;
            coin_reject  <= 1'b0;
            vend         <= 1'b0;
            sel_err      <= 1'b0;
            change_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            vend         <= 1'b0;
            sel_err      <= 1'b0;
            change_valid <= 1'b0;
            busy         <= 1'b0;
            case (state)
                ST_DISPENSE: begin
                    // Output phase: nothing is acted on, coins and selects bounce.
                    state       <= ST_IDLE;
                    coin_reject <= coin_valid;
                    sel_err     <= select_valid;
                end
                default: begin
                    if (cancel && (credit != '0)) begin
                        change       <= credit;
                        credit       <= '0;
                        state        <= ST_DISPENSE;
                        change_valid <= 1'b1;
                        busy         <= 1'b1;
                        sel_err      <= select_valid;
                        coin_reject  <= coin_valid;
                    end else if (select_valid) begin
                        coin_reject <= coin_valid;
                        if (price_ok(price, credit)) begin
                            change       <= credit - price;
                            credit       <= '0;
                            state        <= ST_DISPENSE;
                            vend         <= 1'b1;
                            change_valid <= 1'b1;
                            busy         <= 1'b1;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (coin_ok && coin_fits(credit, coin_cents)) begin
                            credit <= credit + coin_cents;
                            state  <= ST_COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed vector table, a reset-in-dispense sequence,
// and randomized traffic against a behavioural credit model.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       select_valid;
    logic [8:0] price;
    logic       cancel;
    logic [8:0] credit;
    logic       coin_reject;
    logic       vend;
    logic       sel_err;
    logic [8:0] change;
    logic       change_valid;
    logic       busy;

    coin_acceptor dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .select_valid (select_valid),
        .price        (price),
        .cancel       (cancel),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .vend         (vend),
        .sel_err      (sel_err),
        .change       (change),
        .change_valid (change_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       cv;
        logic [1:0] ct;
        logic       sv;
        logic [8:0] pr;
        logic       cn;
        logic [8:0] e_credit;
        logic       e_rej;
        logic       e_vend;
        logic       e_serr;
        logic [8:0] e_change;
        logic       e_cv;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic rst, input logic cv, input logic [1:0] ct,
                                input logic sv, input logic [8:0] pr, input logic cn,
                                input logic [8:0] ecr, input logic erej, input logic evend,
                                input logic eserr, input logic [8:0] echg, input logic ecv,
                                input logic ebusy);
        vec_t v;
        v.rst = rst; v.cv = cv; v.ct = ct; v.sv = sv; v.pr = pr; v.cn = cn;
        v.e_credit = ecr; v.e_rej = erej; v.e_vend = evend; v.e_serr = eserr;
        v.e_change = echg; v.e_cv = ecv; v.e_busy = ebusy;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input vec_t v);
        n_vec++;
        if (credit !== v.e_credit || coin_reject !== v.e_rej || vend !== v.e_vend ||
            sel_err !== v.e_serr || change !== v.e_change || change_valid !== v.e_cv ||
            busy !== v.e_busy) begin
            n_bad++;
            $display("FAIL %s: got credit=%0d rej=%b vend=%b serr=%b change=%0d cv=%b busy=%b; expected credit=%0d rej=%b vend=%b serr=%b change=%0d cv=%b busy=%b",
                     name, credit, coin_reject, vend, sel_err, change, change_valid, busy,
                     v.e_credit, v.e_rej, v.e_vend, v.e_serr, v.e_change, v.e_cv, v.e_busy);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        reset        = v.rst;
        coin_valid   = v.cv;
        coin_type    = v.ct;
        select_valid = v.sv;
        price        = v.pr;
        cancel       = v.cn;
        @(posedge clk);
        #1;
        check(name, v);
    endtask

    // Behavioural model state for the random phase.
    int m_credit;
    int m_change;
    bit m_disp;

    initial begin
        reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00;
        select_valid = 1'b0; price = '0; cancel = 1'b0;

        // Reset, then Q/D/N accumulation and a vend with change.
        add(1,0,0,0,0,0,   0,0,0,0,0,0,0);
        add(0,1,3,0,0,0,  25,0,0,0,0,0,0);
        add(0,1,2,0,0,0,  35,0,0,0,0,0,0);
        add(0,1,1,0,0,0,  40,0,0,0,0,0,0);
        add(0,0,0,1,35,0,  0,0,1,0,5,1,1);
        add(0,0,0,0,0,0,   0,0,0,0,5,0,0);
        // Refused selects (too expensive, not a multiple of 5), then exact price.
        add(0,1,3,0,0,0,  25,0,0,0,5,0,0);
        add(0,1,1,0,0,0,  30,0,0,0,5,0,0);
        add(0,0,0,1,35,0, 30,0,0,1,5,0,0);
        add(0,0,0,1,33,0, 30,0,0,1,5,0,0);
        add(0,0,0,1,0,0,  30,0,0,1,5,0,0);
        add(0,0,0,1,30,0,  0,0,1,0,0,1,1);
        add(0,0,0,0,0,0,   0,0,0,0,0,0,0);
        // Build up to 490 and probe the credit ceiling.
        for (int k = 1; k <= 19; k++)
            add(0,1,3,0,0,0, 9'(25*k),0,0,0,0,0,0);
        add(0,1,2,0,0,0, 485,0,0,0,0,0,0);
        add(0,1,1,0,0,0, 490,0,0,0,0,0,0);
        add(0,1,3,0,0,0, 490,1,0,0,0,0,0);
        add(0,1,2,0,0,0, 500,0,0,0,0,0,0);
        add(0,1,1,0,0,0, 500,1,0,0,0,0,0);
        add(0,1,0,0,0,0, 500,1,0,0,0,0,0);
        add(0,0,0,0,0,1,   0,0,0,0,500,1,1);
        add(0,0,0,0,0,0,   0,0,0,0,500,0,0);
        // Credit 65, then cancel + select + coin all in one cycle.
        add(0,1,3,0,0,0,  25,0,0,0,500,0,0);
        add(0,1,3,0,0,0,  50,0,0,0,500,0,0);
        add(0,1,2,0,0,0,  60,0,0,0,500,0,0);
        add(0,1,1,0,0,0,  65,0,0,0,500,0,0);
        add(0,1,3,1,50,1,  0,1,0,1,65,1,1);
        // Everything presented during DISPENSE bounces; cancel is ignored.
        add(0,1,3,1,20,1,  0,1,0,1,65,0,0);
        add(0,0,0,0,0,0,   0,0,0,0,65,0,0);
        // Cancel with no credit does nothing.
        add(0,0,0,0,0,1,   0,0,0,0,65,0,0);

        foreach (vecs[i]) apply(vecs[i], $sformatf("table[%0d]", i));

        // Reset during the DISPENSE cycle forfeits everything.
        vecs.delete();
        add(0,1,3,0,0,0,  25,0,0,0,65,0,0);
        add(0,1,3,0,0,0,  50,0,0,0,65,0,0);
        add(0,1,3,0,0,0,  75,0,0,0,65,0,0);
        add(0,0,0,1,50,0,  0,0,1,0,25,1,1);
        add(1,1,3,0,0,0,   0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,   0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,   0,0,0,0,0,0,0);
        foreach (vecs[i]) apply(vecs[i], $sformatf("rst_disp[%0d]", i));

        // Randomized traffic against the model; both start from credit 0, change 0, idle.
        m_credit = 0; m_change = 0; m_disp = 0;
        for (int n = 0; n < 3000; n++) begin
            vec_t v;
            int   val;
            v.rst = ($urandom_range(99) == 0);
            v.cv  = ($urandom_range(9) < 6);
            v.ct  = 2'($urandom_range(3));
            v.sv  = ($urandom_range(9) < 2);
            v.cn  = ($urandom_range(19) == 0);
            if ($urandom_range(1) == 0)
                v.pr = 9'(5 * $urandom_range(m_credit / 5 + 2));
            else
                v.pr = 9'($urandom_range(511));
            if (v.cn && m_credit == 0 && !m_disp) begin
                v.cv = 0;
                v.sv = 0;
            end

            v.e_rej = 0; v.e_vend = 0; v.e_serr = 0; v.e_cv = 0; v.e_busy = 0;
            if (v.rst) begin
                m_credit = 0; m_change = 0; m_disp = 0;
            end else if (m_disp) begin
                v.e_rej  = v.cv;
                v.e_serr = v.sv;
                m_disp   = 0;
            end else if (v.cn && m_credit > 0) begin
                m_change = m_credit;
                m_credit = 0;
                m_disp   = 1;
                v.e_cv = 1; v.e_busy = 1;
                v.e_serr = v.sv; v.e_rej = v.cv;
            end else if (v.sv) begin
                v.e_rej = v.cv;
                if (v.pr != 0 && int'(v.pr) % 5 == 0 && int'(v.pr) <= m_credit) begin
                    m_change = m_credit - int'(v.pr);
                    m_credit = 0;
                    m_disp   = 1;
                    v.e_vend = 1; v.e_cv = 1; v.e_busy = 1;
                end else begin
                    v.e_serr = 1;
                end
            end else if (v.cv) begin
                val = (v.ct == 2'd1) ? 5 : (v.ct == 2'd2) ? 10 : (v.ct == 2'd3) ? 25 : 0;
                if (val != 0 && m_credit + val <= 500)
                    m_credit += val;
                else
                    v.e_rej = 1;
            end
            v.e_credit = 9'(m_credit);
            v.e_change = 9'(m_change);
            apply(v, $sformatf("rand[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
